// File: rtl/eth_phy_rx_frame_sync_ml.sv
// eth_phy_rx_frame_sync_ml
//   Multi-lane 10GBASE-R block-lock (frame sync). Each lane watches its 2-bit
//   sync header. While unlocked it requests SERDES bitslips until it sees a
//   full window of valid headers. While locked it drops lock when too many
//   invalid headers arrive in one window. A lane that keeps slipping without
//   locking escalates to a one-cycle SERDES reset request.
//
//   Optional build macro: ETH_FRAME_SYNC_STATS_EN (per-lane saturating
//   lock-loss and bitslip counters; stat ports are 0 when undefined).
//
// Ports
//   rx_clk                clock
//   rx_rst                synchronous active-high reset
//   serdes_rx_hdr         per-lane sync header, lane n at [2n+1:2n]
//   serdes_rx_hdr_valid   per-lane header qualifier (gearbox gaps)
//   cfg_lane_enable       per-lane enable; 0 holds the lane in reset
//   serdes_rx_bitslip     per-lane bitslip request
//   serdes_rx_reset_req   per-lane one-cycle SERDES reset request
//   rx_block_lock         per-lane block lock
//   rx_all_lock           all enabled lanes locked (0 if none enabled)
//   stat_lock_loss_count  per-lane lock-loss count, 8 bits per lane
//   stat_bitslip_count    per-lane bitslip count, 8 bits per lane
//
// Lane FSM
//   state   | meaning
//   MONITOR | headers counted, lock decisions made
//   SLIP_HI | bitslip asserted, headers ignored
//   SLIP_LO | post-slip hold-off, headers ignored

module eth_phy_rx_frame_sync_ml #(
  parameter int NUM_LANES           = 1,
  parameter int HDR_WIDTH           = 2,
  parameter int SH_CNT_MAX          = 64,
  parameter int SH_INVALID_MAX      = 16,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int MAX_SLIPS           = 132
) (
  input  logic                           rx_clk,
  input  logic                           rx_rst,
  input  logic [NUM_LANES*HDR_WIDTH-1:0] serdes_rx_hdr,
  input  logic [NUM_LANES-1:0]           serdes_rx_hdr_valid,
  input  logic [NUM_LANES-1:0]           cfg_lane_enable,
  output logic [NUM_LANES-1:0]           serdes_rx_bitslip,
  output logic [NUM_LANES-1:0]           serdes_rx_reset_req,
  output logic [NUM_LANES-1:0]           rx_block_lock,
  output logic                           rx_all_lock,
  output logic [NUM_LANES*8-1:0]         stat_lock_loss_count,
  output logic [NUM_LANES*8-1:0]         stat_bitslip_count
);

  localparam int CNT_W   = $clog2(SH_CNT_MAX);
  localparam int INV_W   = $clog2(SH_INVALID_MAX) + 1;
  localparam int TMR_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                           BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int SLIP_W  = (MAX_SLIPS > 1) ? $clog2(MAX_SLIPS + 1) : 1;

  typedef enum logic [1:0] {
    ST_MONITOR = 2'd0,
    ST_SLIP_HI = 2'd1,
    ST_SLIP_LO = 2'd2
  } state_t;

  state_t            state_q  [NUM_LANES];
  state_t            state_d  [NUM_LANES];
  logic [CNT_W-1:0]  sh_cnt_q [NUM_LANES];
  logic [CNT_W-1:0]  sh_cnt_d [NUM_LANES];
  logic [INV_W-1:0]  inv_q    [NUM_LANES];
  logic [INV_W-1:0]  inv_d    [NUM_LANES];
  logic [TMR_W-1:0]  tmr_q    [NUM_LANES];
  logic [TMR_W-1:0]  tmr_d    [NUM_LANES];
  logic [SLIP_W-1:0] slip_q   [NUM_LANES];
  logic [SLIP_W-1:0] slip_d   [NUM_LANES];

  logic [NUM_LANES-1:0] lock_d;
  logic [NUM_LANES-1:0] bitslip_d;
  logic [NUM_LANES-1:0] rst_req_d;
  logic [NUM_LANES-1:0] slip_entry;
  logic                 all_lock_d;
  logic [HDR_WIDTH-1:0] hdr;
  logic                 hdr_ok;
  logic                 win_last;

  always_comb begin
    hdr        = '0;
    hdr_ok     = 1'b0;
    win_last   = 1'b0;
    lock_d     = rx_block_lock;
    bitslip_d  = '0;
    rst_req_d  = '0;
    slip_entry = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      state_d[n]  = state_q[n];
      sh_cnt_d[n] = sh_cnt_q[n];
      inv_d[n]    = inv_q[n];
      tmr_d[n]    = tmr_q[n];
      slip_d[n]   = slip_q[n];

      hdr      = serdes_rx_hdr[n*HDR_WIDTH +: HDR_WIDTH];
      hdr_ok   = ^hdr;  // 01 / 10 are the only legal sync headers
      win_last = (sh_cnt_q[n] == CNT_W'(SH_CNT_MAX - 1));

      case (state_q[n])
        ST_MONITOR: begin
          if (serdes_rx_hdr_valid[n]) begin
            if (hdr_ok) begin
              if (win_last) begin
                sh_cnt_d[n] = '0;
                inv_d[n]    = '0;
                if (inv_q[n] == '0) lock_d[n] = 1'b1;
              end else begin
                sh_cnt_d[n] = sh_cnt_q[n] + CNT_W'(1);
              end
            end else if (!rx_block_lock[n]) begin
              slip_entry[n] = 1'b1;
            end else if (inv_q[n] == INV_W'(SH_INVALID_MAX - 1)) begin
              lock_d[n]     = 1'b0;
              slip_entry[n] = 1'b1;
            end else if (win_last) begin
              sh_cnt_d[n] = '0;
              inv_d[n]    = '0;
            end else begin
              sh_cnt_d[n] = sh_cnt_q[n] + CNT_W'(1);
              inv_d[n]    = inv_q[n] + INV_W'(1);
            end
          end
        end
        ST_SLIP_HI: begin
          if (tmr_q[n] == '0) begin
            if (BITSLIP_LOW_CYCLES == 0) begin
              state_d[n] = ST_MONITOR;
            end else begin
              state_d[n] = ST_SLIP_LO;
              tmr_d[n]   = TMR_W'(BITSLIP_LOW_CYCLES - 1);
            end
          end else begin
            tmr_d[n] = tmr_q[n] - TMR_W'(1);
          end
        end
        ST_SLIP_LO: begin
          if (tmr_q[n] == '0) state_d[n] = ST_MONITOR;
          else                tmr_d[n]   = tmr_q[n] - TMR_W'(1);
        end
        default: state_d[n] = ST_MONITOR;
      endcase

      if (slip_entry[n]) begin
        state_d[n]  = ST_SLIP_HI;
        tmr_d[n]    = TMR_W'(BITSLIP_HIGH_CYCLES - 1);
        sh_cnt_d[n] = '0;
        inv_d[n]    = '0;
      end

      // Escalation fires together with the slip that reaches the limit.
      if (lock_d[n]) begin
        slip_d[n] = '0;
      end else if (MAX_SLIPS != 0 && slip_entry[n]) begin
        if (slip_q[n] == SLIP_W'(MAX_SLIPS - 1)) begin
          slip_d[n]    = '0;
          rst_req_d[n] = 1'b1;
        end else begin
          slip_d[n] = slip_q[n] + SLIP_W'(1);
        end
      end

      if (!cfg_lane_enable[n]) begin
        state_d[n]    = ST_MONITOR;
        sh_cnt_d[n]   = '0;
        inv_d[n]      = '0;
        tmr_d[n]      = '0;
        slip_d[n]     = '0;
        lock_d[n]     = 1'b0;
        rst_req_d[n]  = 1'b0;
        slip_entry[n] = 1'b0;
      end

      bitslip_d[n] = (state_d[n] == ST_SLIP_HI);
    end

    all_lock_d = (|cfg_lane_enable) & (&(rx_block_lock | ~cfg_lane_enable));
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      for (int n = 0; n < NUM_LANES; n++) begin
        state_q[n]  <= ST_MONITOR;
        sh_cnt_q[n] <= '0;
        inv_q[n]    <= '0;
        tmr_q[n]    <= '0;
        slip_q[n]   <= '0;
      end
      rx_block_lock       <= '0;
      serdes_rx_bitslip   <= '0;
      serdes_rx_reset_req <= '0;
      rx_all_lock         <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_LANES; n++) begin
        state_q[n]  <= state_d[n];
        sh_cnt_q[n] <= sh_cnt_d[n];
        inv_q[n]    <= inv_d[n];
        tmr_q[n]    <= tmr_d[n];
        slip_q[n]   <= slip_d[n];
      end
      rx_block_lock       <= lock_d;
      serdes_rx_bitslip   <= bitslip_d;
      serdes_rx_reset_req <= rst_req_d;
      rx_all_lock         <= all_lock_d;
    end
  end

`ifdef ETH_FRAME_SYNC_STATS_EN
  logic [7:0] loss_q [NUM_LANES];
  logic [7:0] bs_q   [NUM_LANES];

  // Counters survive lane disable; a disable while locked counts as a loss.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      for (int n = 0; n < NUM_LANES; n++) begin
        loss_q[n] <= '0;
        bs_q[n]   <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_LANES; n++) begin
        if (rx_block_lock[n] && !lock_d[n] && loss_q[n] != 8'hFF)
          loss_q[n] <= loss_q[n] + 8'd1;
        if (slip_entry[n] && bs_q[n] != 8'hFF)
          bs_q[n] <= bs_q[n] + 8'd1;
      end
    end
  end

  always_comb begin
    stat_lock_loss_count = '0;
    stat_bitslip_count   = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      stat_lock_loss_count[n*8 +: 8] = loss_q[n];
      stat_bitslip_count[n*8 +: 8]   = bs_q[n];
    end
  end
`else
  assign stat_lock_loss_count = '0;
  assign stat_bitslip_count   = '0;
`endif

endmodule

// File: tb/tb_eth_phy_rx_frame_sync_ml.sv
// Bench for eth_phy_rx_frame_sync_ml: 4 lanes, MAX_SLIPS=4, other parameters
// at their defaults. A timestamp-based lane model predicts every output each
// cycle; directed scenarios add hand-computed literal expectations.

module tb_eth_phy_rx_frame_sync_ml;

  localparam int NL   = 4;
  localparam int MAXS = 4;
  localparam int HI   = 1;
  localparam int LO   = 8;
  localparam int CNTM = 64;
  localparam int INVM = 16;
`ifdef ETH_FRAME_SYNC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [2*NL-1:0] hdr;
  logic [NL-1:0] hv;
  logic [NL-1:0] en;
  logic [NL-1:0] bitslip;
  logic [NL-1:0] reset_req;
  logic [NL-1:0] block_lock;
  logic          all_lock;
  logic [NL*8-1:0] stat_loss;
  logic [NL*8-1:0] stat_bs;

  always #5 clk = ~clk;

  eth_phy_rx_frame_sync_ml #(
    .NUM_LANES(NL),
    .MAX_SLIPS(MAXS)
  ) dut (
    .rx_clk              (clk),
    .rx_rst              (rst),
    .serdes_rx_hdr       (hdr),
    .serdes_rx_hdr_valid (hv),
    .cfg_lane_enable     (en),
    .serdes_rx_bitslip   (bitslip),
    .serdes_rx_reset_req (reset_req),
    .rx_block_lock       (block_lock),
    .rx_all_lock         (all_lock),
    .stat_lock_loss_count(stat_loss),
    .stat_bitslip_count  (stat_bs)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: a slip decided at edge c blinds the lane for edges c+1..c+HI+LO
  // and shows bitslip after edges c..c+HI-1.
  longint edge_k = 0;
  bit     started = 1'b0;
  bit     m_lock    [NL];
  int     m_seen    [NL];
  int     m_bad     [NL];
  int     m_slips   [NL];
  longint m_slip_at [NL];
  bit     m_bitslip [NL];
  bit     m_req     [NL];
  int     m_loss    [NL];
  int     m_bs      [NL];
  bit     m_all;
  bit     all_ok;

  task automatic model_lane(int l, logic [1:0] h, logic v, logic e);
    bit was_locked;
    bit slip;
    was_locked = m_lock[l];
    slip       = 1'b0;
    m_req[l]   = 1'b0;
    if (!e) begin
      m_lock[l]    = 1'b0;
      m_seen[l]    = 0;
      m_bad[l]     = 0;
      m_slips[l]   = 0;
      m_slip_at[l] = -1000;
    end else if (v && (edge_k - m_slip_at[l] > HI + LO)) begin
      if (h == 2'b01 || h == 2'b10) begin
        if (m_seen[l] == CNTM - 1) begin
          if (m_bad[l] == 0) m_lock[l] = 1'b1;
          m_seen[l] = 0;
          m_bad[l]  = 0;
        end else begin
          m_seen[l]++;
        end
      end else if (!m_lock[l]) begin
        slip = 1'b1;
      end else if (m_bad[l] == INVM - 1) begin
        m_lock[l] = 1'b0;
        slip      = 1'b1;
      end else if (m_seen[l] == CNTM - 1) begin
        m_seen[l] = 0;
        m_bad[l]  = 0;
      end else begin
        m_seen[l]++;
        m_bad[l]++;
      end
      if (slip) begin
        m_seen[l] = 0;
        m_bad[l]  = 0;
      end
    end
    if (m_lock[l]) m_slips[l] = 0;
    if (slip) begin
      m_slip_at[l] = edge_k;
      if (m_bs[l] < 255) m_bs[l]++;
      if (!m_lock[l]) begin
        m_slips[l]++;
        if (m_slips[l] == MAXS) begin
          m_req[l]   = 1'b1;
          m_slips[l] = 0;
        end
      end
    end
    if (was_locked && !m_lock[l] && m_loss[l] < 255) m_loss[l]++;
    m_bitslip[l] = (edge_k >= m_slip_at[l]) && (edge_k - m_slip_at[l] < HI);
  endtask

  always @(posedge clk) begin
    edge_k++;
    if (rst) begin
      for (int l = 0; l < NL; l++) begin
        m_lock[l] = 1'b0; m_seen[l] = 0; m_bad[l] = 0; m_slips[l] = 0;
        m_slip_at[l] = -1000; m_bitslip[l] = 1'b0; m_req[l] = 1'b0;
        m_loss[l] = 0; m_bs[l] = 0;
      end
      m_all   = 1'b0;
      started = 1'b1;
    end else begin
      all_ok = (en != '0);
      for (int l = 0; l < NL; l++)
        if (en[l] && !m_lock[l]) all_ok = 1'b0;
      m_all = all_ok;
      for (int l = 0; l < NL; l++)
        model_lane(l, hdr[2*l +: 2], hv[l], en[l]);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int l = 0; l < NL; l++) begin
        check($sformatf("bitslip[%0d]", l), 32'(bitslip[l]), 32'(m_bitslip[l]));
        check($sformatf("reset_req[%0d]", l), 32'(reset_req[l]), 32'(m_req[l]));
        check($sformatf("block_lock[%0d]", l), 32'(block_lock[l]), 32'(m_lock[l]));
        check($sformatf("stat_loss[%0d]", l), 32'(stat_loss[l*8 +: 8]),
              STATS ? m_loss[l] : 0);
        check($sformatf("stat_bs[%0d]", l), 32'(stat_bs[l*8 +: 8]),
              STATS ? m_bs[l] : 0);
      end
      check("all_lock", 32'(all_lock), 32'(m_all));
    end
  end

  task automatic cyc(logic [7:0] h, logic [3:0] v, int n);
    for (int i = 0; i < n; i++) begin
      hdr = h;
      hv  = v;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hv  = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int cnt_bs;
  int cnt_req;
  int req_alone;

  initial begin
    rst = 1'b1; en = 4'b0001; hdr = '0; hv = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset lock", 32'(block_lock), 32'h0);
    check("reset bitslip", 32'(bitslip), 32'h0);
    check("reset all_lock", 32'(all_lock), 32'h0);

    // 64 valid headers on lane 0
    cyc(8'h55, 4'hF, 63);
    check("t1 lock after 63", 32'(block_lock[0]), 32'h0);
    cyc(8'h55, 4'hF, 1);
    check("t1 lock after 64", 32'(block_lock[0]), 32'h1);
    check("t1 all_lock lags", 32'(all_lock), 32'h0);
    cyc(8'h00, 4'h0, 1);
    check("t1 all_lock", 32'(all_lock), 32'h1);

    // 63 valid then invalid: slip, then hold-off ignores headers
    do_reset();
    cyc(8'h55, 4'hF, 63);
    cyc(8'h00, 4'hF, 1);
    check("t2 no lock", 32'(block_lock[0]), 32'h0);
    check("t2 bitslip", 32'(bitslip[0]), 32'h1);
    cnt_bs = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(8'h00, 4'hF, 1);
      cnt_bs += int'(bitslip[0]);
    end
    check("t2 holdoff slips", 32'(cnt_bs), 32'h0);
    cyc(8'h00, 4'hF, 1);
    check("t2 next slip", 32'(bitslip[0]), 32'h1);

    // locked: 15 invalid in a window keeps lock, 16 drops it
    do_reset();
    cyc(8'h55, 4'hF, 64);
    check("t3 locked", 32'(block_lock[0]), 32'h1);
    for (int i = 0; i < 64; i++)
      cyc((i % 4 == 3 && i < 60) ? 8'h00 : 8'h55, 4'hF, 1);
    check("t3 lock held 15", 32'(block_lock[0]), 32'h1);
    for (int i = 0; i < 60; i++)
      cyc((i % 4 == 0) ? 8'h00 : 8'h55, 4'hF, 1);
    check("t3 lock before 16th", 32'(block_lock[0]), 32'h1);
    cyc(8'h00, 4'hF, 1);
    check("t3 lock lost", 32'(block_lock[0]), 32'h0);
    check("t3 bitslip", 32'(bitslip[0]), 32'h1);
    check("t3 stat_loss", 32'(stat_loss[7:0]), STATS ? 32'h1 : 32'h0);

    // after loss: 7 valid and 1 invalid slips again at once
    cyc(8'h55, 4'h0, 9);
    cyc(8'h55, 4'hF, 7);
    check("t4 no slip yet", 32'(bitslip[0]), 32'h0);
    cyc(8'h00, 4'hF, 1);
    check("t4 second slip", 32'(bitslip[0]), 32'h1);
    check("t4 still unlocked", 32'(block_lock[0]), 32'h0);

    // continuous invalid headers: reset request every 4th slip
    do_reset();
    cnt_bs = 0; cnt_req = 0; req_alone = 0;
    for (int i = 0; i < 85; i++) begin
      cyc(8'h00, 4'hF, 1);
      cnt_bs  += int'(bitslip[0]);
      cnt_req += int'(reset_req[0]);
      if (reset_req[0] && !bitslip[0]) req_alone++;
    end
    check("t5 slips", 32'(cnt_bs), 32'd9);
    check("t5 reset_reqs", 32'(cnt_req), 32'd2);
    check("t5 req with slip", 32'(req_alone), 32'd0);
    check("t5 stat_bs", 32'(stat_bs[7:0]), STATS ? 32'd9 : 32'd0);

    // reset mid-slip aborts the hold-off
    do_reset();
    cyc(8'h00, 4'hF, 1);
    check("t5 abort slip", 32'(bitslip[0]), 32'h1);
    rst = 1'b1;
    cyc(8'h00, 4'hF, 1);
    rst = 1'b0;
    check("t5 abort bitslip low", 32'(bitslip[0]), 32'h0);
    cyc(8'h00, 4'hF, 1);
    check("t5 no holdoff", 32'(bitslip[0]), 32'h1);

    // four lanes: lane 3 disabled, then enabled
    do_reset();
    en = 4'b0111;
    cyc(8'h19, 4'hF, 64);
    check("t6 locks", 32'(block_lock), 32'h7);
    check("t6 lane3 quiet", 32'(bitslip), 32'h0);
    cyc(8'h19, 4'hF, 1);
    check("t6 all_lock 3 lanes", 32'(all_lock), 32'h1);
    en = 4'b1111;
    cyc(8'h59, 4'hF, 1);
    check("t6 all_lock drop", 32'(all_lock), 32'h0);
    cyc(8'h59, 4'h7, 5);
    cyc(8'h59, 4'hF, 62);
    check("t6 lane3 63 hdrs", 32'(block_lock[3]), 32'h0);
    check("t6 all_lock still 0", 32'(all_lock), 32'h0);
    cyc(8'h59, 4'hF, 1);
    check("t6 lane3 lock", 32'(block_lock[3]), 32'h1);
    cyc(8'h59, 4'hF, 1);
    check("t6 all_lock 4 lanes", 32'(all_lock), 32'h1);
    en = 4'b0000;
    cyc(8'h59, 4'hF, 2);
    check("t6 none enabled", 32'(all_lock), 32'h0);
    check("t6 locks cleared", 32'(block_lock), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
